// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class character LCD writer.
package lcd_pkg;

    // Top-level controller states.
    typedef enum logic [3:0] {
        PWRUP      = 4'd0,
        INIT_FS    = 4'd1,
        INIT_DISP  = 4'd2,
        INIT_CLR   = 4'd3,
        INIT_ENTRY = 4'd4,
        IDLE       = 4'd5,
        WR_CHAR    = 4'd6,
        SET_ADDR   = 4'd7,
        CLR        = 4'd8
    } lcd_state_e;

    // Phases of one byte transfer on the LCD bus.
    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_SETUP = 2'd1,
        BUS_EHIGH = 2'd2,
        BUS_WAIT  = 2'd3
    } bus_phase_e;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ROW0_BASE     = 8'h00;
    localparam logic [7:0] ROW1_BASE     = 8'h40;

    // Set-DDRAM-address command that puts the cursor at column 0 of a row.
    function automatic logic [7:0] ddram_addr_cmd(input logic row);
        logic [7:0] base_v;
        if (row) begin
            base_v = ROW1_BASE;
        end else begin
            base_v = ROW0_BASE;
        end
        return CMD_SET_DDRAM | base_v;
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD write transaction: setup cycle, E pulse, then the settle wait.
// done is the terminal count of the wait so the controller can chain the
// next byte on the same edge without an idle bubble.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int T_E_CYC   = 50,
    parameter int T_CMD_CYC = 4_000,
    parameter int T_CLR_CYC = 164_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] wr_byte,
    input  logic              rs,
    input  logic              long_wait,
    output logic [DATA_W-1:0] lcd_d,
    output logic              lcd_rs,
    output logic              lcd_e,
    output logic              done
);

    localparam int T_MAX0 = (T_E_CYC > T_CMD_CYC) ? T_E_CYC : T_CMD_CYC;
    localparam int T_MAX  = (T_MAX0 > T_CLR_CYC) ? T_MAX0 : T_CLR_CYC;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    bus_phase_e        phase_r;
    bus_phase_e        phase_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic              lcd_e_r;
    logic              e_nx_s;
    logic              long_r;
    logic [DATA_W-1:0] lcd_d_r;
    logic              lcd_rs_r;
    logic [CNT_W-1:0]  wait_last_s;
    logic              done_s;

    assign wait_last_s = long_r ? CNT_W'(T_CLR_CYC - 1) : CNT_W'(T_CMD_CYC - 1);
    assign done_s      = (phase_r == BUS_WAIT) && (cnt_r == wait_last_s);

    // Next phase, counter and strobe level for the transfer in progress.
    always_comb begin
        phase_nx_s = phase_r;
        cnt_nx_s   = cnt_r;
        e_nx_s     = lcd_e_r;
        if (start) begin
            phase_nx_s = BUS_SETUP;
            cnt_nx_s   = {CNT_W{1'b0}};
            e_nx_s     = 1'b0;
        end else begin
            case (phase_r)
                BUS_IDLE: begin
                    phase_nx_s = BUS_IDLE;
                    e_nx_s     = 1'b0;
                end
                BUS_SETUP: begin
                    phase_nx_s = BUS_EHIGH;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    e_nx_s     = 1'b1;
                end
                BUS_EHIGH: begin
                    if (cnt_r == CNT_W'(T_E_CYC - 1)) begin
                        phase_nx_s = BUS_WAIT;
                        cnt_nx_s   = {CNT_W{1'b0}};
                        e_nx_s     = 1'b0;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                BUS_WAIT: begin
                    if (done_s) begin
                        phase_nx_s = BUS_IDLE;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    phase_nx_s = BUS_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    e_nx_s     = 1'b0;
                end
            endcase
        end
    end

    // Phase/counter registers; byte, rs and wait length latched on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r  <= BUS_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            lcd_e_r  <= 1'b0;
            long_r   <= 1'b0;
            lcd_d_r  <= {DATA_W{1'b0}};
            lcd_rs_r <= 1'b0;
        end else begin
            phase_r <= phase_nx_s;
            cnt_r   <= cnt_nx_s;
            lcd_e_r <= e_nx_s;
            if (start) begin
                long_r   <= long_wait;
                lcd_d_r  <= wr_byte;
                lcd_rs_r <= rs;
            end
        end
    end

    assign lcd_d  = lcd_d_r;
    assign lcd_rs = lcd_rs_r;
    assign lcd_e  = lcd_e_r;
    assign done   = done_s;

endmodule

// File: rtl/lcd_char_writer.sv
// Character LCD controller: power-up init, then letter/space/newline/clear
// requests turned into timed bus writes with cursor tracking and line wrap.
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int T_PWRUP_CYC = 4_000_000,
    parameter int T_E_CYC     = 50,
    parameter int T_CMD_CYC   = 4_000,
    parameter int T_CLR_CYC   = 164_000,
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              sysclk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] char_in,
    input  logic              letter_req,
    input  logic              word_req,
    input  logic              done_req,
    input  logic              clear_req,
    output logic              ready,
    output logic [DATA_W-1:0] lcd_d,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [COL_W-1:0]  cursor_col,
    output logic              cursor_row
);

    localparam int PWR_W = $clog2(T_PWRUP_CYC + 1);

    lcd_state_e        state_r;
    lcd_state_e        state_nx_s;
    logic [PWR_W-1:0]  pwr_cnt_r;
    logic              ready_r;
    logic [COL_W-1:0]  cursor_col_r;
    logic              cursor_row_r;
    logic              addr_row_r;
    logic              req_ok_s;
    logic              col_last_s;
    logic              bus_start_s;
    logic [DATA_W-1:0] bus_byte_s;
    logic              bus_rs_s;
    logic              bus_long_s;
    logic              bus_done_s;

    // Row below the given one, wrapping back to row 0 on the last row.
    function automatic logic next_row(input logic row);
        return (ROWS > 1) ? ~row : 1'b0;
    endfunction

    assign req_ok_s   = (state_r == IDLE) && ready_r;
    assign col_last_s = (cursor_col_r == COL_W'(COLS - 1));
    assign bus_long_s = !bus_rs_s && (bus_byte_s == CMD_CLEAR);

    // Next state and the byte to launch on the bus when a state is entered.
    always_comb begin
        state_nx_s  = state_r;
        bus_start_s = 1'b0;
        bus_byte_s  = {DATA_W{1'b0}};
        bus_rs_s    = 1'b0;
        case (state_r)
            PWRUP: begin
                if (pwr_cnt_r == PWR_W'(T_PWRUP_CYC - 1)) begin
                    state_nx_s  = INIT_FS;
                    bus_start_s = 1'b1;
                    bus_byte_s  = CMD_FUNC_SET;
                end else begin
                    state_nx_s = PWRUP;
                end
            end
            INIT_FS: begin
                if (bus_done_s) begin
                    state_nx_s  = INIT_DISP;
                    bus_start_s = 1'b1;
                    bus_byte_s  = CMD_DISP_ON;
                end else begin
                    state_nx_s = INIT_FS;
                end
            end
            INIT_DISP: begin
                if (bus_done_s) begin
                    state_nx_s  = INIT_CLR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = CMD_CLEAR;
                end else begin
                    state_nx_s = INIT_DISP;
                end
            end
            INIT_CLR: begin
                if (bus_done_s) begin
                    state_nx_s  = INIT_ENTRY;
                    bus_start_s = 1'b1;
                    bus_byte_s  = CMD_ENTRY;
                end else begin
                    state_nx_s = INIT_CLR;
                end
            end
            INIT_ENTRY: begin
                if (bus_done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = INIT_ENTRY;
                end
            end
            IDLE: begin
                if (!req_ok_s) begin
                    state_nx_s = IDLE;
                end else if (clear_req) begin
                    state_nx_s  = CLR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = CMD_CLEAR;
                end else if (done_req) begin
                    state_nx_s  = SET_ADDR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = ddram_addr_cmd(next_row(cursor_row_r));
                end else if (word_req) begin
                    state_nx_s  = WR_CHAR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = ASCII_SPACE;
                    bus_rs_s    = 1'b1;
                end else if (letter_req) begin
                    state_nx_s  = WR_CHAR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = char_in;
                    bus_rs_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WR_CHAR: begin
                if (bus_done_s && col_last_s) begin
                    state_nx_s  = SET_ADDR;
                    bus_start_s = 1'b1;
                    bus_byte_s  = ddram_addr_cmd(next_row(cursor_row_r));
                end else if (bus_done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WR_CHAR;
                end
            end
            SET_ADDR, CLR: begin
                if (bus_done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = PWRUP;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge sysclk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= PWRUP;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Power-up delay counter; only runs while in PWRUP.
    always_ff @(posedge sysclk or negedge clr_n) begin
        if (!clr_n) begin
            pwr_cnt_r <= {PWR_W{1'b0}};
        end else if (state_r == PWRUP) begin
            pwr_cnt_r <= pwr_cnt_r + PWR_W'(1);
        end else begin
            pwr_cnt_r <= {PWR_W{1'b0}};
        end
    end

    // ready is high exactly while the controller will stay in IDLE.
    always_ff @(posedge sysclk or negedge clr_n) begin
        if (!clr_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_nx_s == IDLE);
        end
    end

    // Cursor tracking; moves when the owning bus transaction completes.
    always_ff @(posedge sysclk or negedge clr_n) begin
        if (!clr_n) begin
            cursor_col_r <= {COL_W{1'b0}};
            cursor_row_r <= 1'b0;
            addr_row_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_ok_s && !clear_req && done_req) begin
                        addr_row_r <= next_row(cursor_row_r);
                    end
                end
                WR_CHAR: begin
                    if (bus_done_s && col_last_s) begin
                        cursor_col_r <= {COL_W{1'b0}};
                        cursor_row_r <= next_row(cursor_row_r);
                        addr_row_r   <= next_row(cursor_row_r);
                    end else if (bus_done_s) begin
                        cursor_col_r <= cursor_col_r + COL_W'(1);
                    end
                end
                SET_ADDR: begin
                    if (bus_done_s) begin
                        cursor_col_r <= {COL_W{1'b0}};
                        cursor_row_r <= addr_row_r;
                    end
                end
                CLR: begin
                    if (bus_done_s) begin
                        cursor_col_r <= {COL_W{1'b0}};
                        cursor_row_r <= 1'b0;
                    end
                end
                default: begin
                    cursor_col_r <= cursor_col_r;
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .DATA_W    (DATA_W),
        .T_E_CYC   (T_E_CYC),
        .T_CMD_CYC (T_CMD_CYC),
        .T_CLR_CYC (T_CLR_CYC)
    ) u_bus (
        .clk       (sysclk),
        .rst_n     (clr_n),
        .start     (bus_start_s),
        .wr_byte   (bus_byte_s),
        .rs        (bus_rs_s),
        .long_wait (bus_long_s),
        .lcd_d     (lcd_d),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .done      (bus_done_s)
    );

    assign ready      = ready_r;
    assign lcd_rw     = 1'b0;
    assign cursor_col = cursor_col_r;
    assign cursor_row = cursor_row_r;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timing parameters.
module tb_lcd_char_writer;

    localparam int COLS = 4;

    logic       sysclk     = 1'b0;
    logic       clr_n      = 1'b0;
    logic [7:0] char_in    = 8'h00;
    logic       letter_req = 1'b0;
    logic       word_req   = 1'b0;
    logic       done_req   = 1'b0;
    logic       clear_req  = 1'b0;
    logic       ready;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [1:0] cursor_col;
    logic       cursor_row;

    lcd_char_writer #(
        .DATA_W      (8),
        .COLS        (COLS),
        .ROWS        (2),
        .T_PWRUP_CYC (20),
        .T_E_CYC     (2),
        .T_CMD_CYC   (5),
        .T_CLR_CYC   (12)
    ) dut (
        .sysclk     (sysclk),
        .clr_n      (clr_n),
        .char_in    (char_in),
        .letter_req (letter_req),
        .word_req   (word_req),
        .done_req   (done_req),
        .clear_req  (clear_req),
        .ready      (ready),
        .lcd_d      (lcd_d),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Strobe monitor: records byte/rs at each E rise and E width at each fall.
    logic       e_prev = 1'b0;
    int         rise_at = 0;
    logic [7:0] sd_q[$];
    logic       srs_q[$];
    int         shi_q[$];
    int         srise_q[$];
    int         sfall_q[$];

    always @(negedge sysclk) begin
        if (lcd_e && !e_prev) begin
            sd_q.push_back(lcd_d);
            srs_q.push_back(lcd_rs);
            srise_q.push_back(cyc);
            rise_at = cyc;
        end
        if (!lcd_e && e_prev) begin
            shi_q.push_back(cyc - rise_at);
            sfall_q.push_back(cyc);
        end
        e_prev = lcd_e;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    int rel_cyc = 0;
    int low;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        sd_q.delete();
        srs_q.delete();
        shi_q.delete();
        srise_q.delete();
        sfall_q.delete();
    endtask

    task automatic send_req(input logic l, input logic w, input logic d, input logic c,
                            input logic [7:0] ch);
        @(negedge sysclk);
        letter_req = l;
        word_req   = w;
        done_req   = d;
        clear_req  = c;
        char_in    = ch;
        @(negedge sysclk);
        letter_req = 1'b0;
        word_req   = 1'b0;
        done_req   = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int lowcyc);
        lowcyc = 0;
        while (!ready && lowcyc < 1000) begin
            lowcyc++;
            @(negedge sysclk);
        end
        check_val({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic [7:0] d,
                                input logic rs);
        if (idx < sd_q.size() && idx < shi_q.size()) begin
            check_val({tag, "_d"}, {24'd0, sd_q[idx]}, {24'd0, d});
            check_val({tag, "_rs"}, {31'd0, srs_q[idx]}, {31'd0, rs});
            check_val({tag, "_ehi"}, shi_q[idx], 32'd2);
        end else begin
            check_val({tag, "_present"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_init(input string tag);
        int lc;
        int rdy_cyc;
        wait_ready(tag, lc);
        rdy_cyc = cyc;
        check_val({tag, "_nstrobes"}, sd_q.size(), 32'd4);
        check_strobe({tag, "_fs"}, 0, 8'h38, 1'b0);
        check_strobe({tag, "_disp"}, 1, 8'h0C, 1'b0);
        check_strobe({tag, "_clr"}, 2, 8'h01, 1'b0);
        check_strobe({tag, "_entry"}, 3, 8'h06, 1'b0);
        if (srise_q.size() >= 4 && sfall_q.size() >= 4) begin
            check_val({tag, "_pwrup_quiet"}, {31'd0, (srise_q[0] - rel_cyc) >= 20}, 32'd1);
            check_val({tag, "_clr_gap"}, {31'd0, (srise_q[3] - sfall_q[2]) >= 12}, 32'd1);
            check_val({tag, "_ready_lat"}, rdy_cyc - sfall_q[3], 32'd5);
        end else begin
            check_val({tag, "_timing_present"}, 32'd0, 32'd1);
        end
        check_val({tag, "_col"}, {30'd0, cursor_col}, 32'd0);
        check_val({tag, "_row"}, {31'd0, cursor_row}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        check_val("rst_e", {31'd0, lcd_e}, 32'd0);
        check_val("rst_d", {24'd0, lcd_d}, 32'd0);
        check_val("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check_val("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_col", {30'd0, cursor_col}, 32'd0);
        check_val("rst_row", {31'd0, cursor_row}, 32'd0);
        rel_cyc = cyc;
        clr_n = 1'b1;
        clear_q();
        check_init("init");

        // Single letter 'A'.
        clear_q();
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
        wait_ready("a", low);
        check_val("a_busy_cyc", low, 32'd8);
        check_val("a_nstrobes", sd_q.size(), 32'd1);
        check_strobe("a", 0, 8'h41, 1'b1);
        check_val("a_col", {30'd0, cursor_col}, 32'd1);
        check_val("a_row", {31'd0, cursor_row}, 32'd0);

        // clear beats word and letter raised in the same cycle.
        clear_q();
        send_req(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
        wait_ready("clr", low);
        check_val("clr_busy_cyc", low, 32'd15);
        check_val("clr_nstrobes", sd_q.size(), 32'd1);
        check_strobe("clr", 0, 8'h01, 1'b0);
        check_val("clr_col", {30'd0, cursor_col}, 32'd0);
        check_val("clr_row", {31'd0, cursor_row}, 32'd0);

        // Fill row 0; the last letter wraps to row 1 with a 0xC0 address write.
        clear_q();
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h57);
        wait_ready("w", low);
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h58);
        wait_ready("x", low);
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h59);
        wait_ready("y", low);
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        wait_ready("z", low);
        check_val("wrap1_nstrobes", sd_q.size(), 32'd5);
        check_strobe("wrap1_w", 0, 8'h57, 1'b1);
        check_strobe("wrap1_x", 1, 8'h58, 1'b1);
        check_strobe("wrap1_y", 2, 8'h59, 1'b1);
        check_strobe("wrap1_z", 3, 8'h5A, 1'b1);
        check_strobe("wrap1_addr", 4, 8'hC0, 1'b0);
        check_val("wrap1_col", {30'd0, cursor_col}, 32'd0);
        check_val("wrap1_row", {31'd0, cursor_row}, 32'd1);

        // Row 1 last column: one letter wraps back to row 0.
        for (int i = 0; i < COLS - 1; i++) begin
            send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h61);
            wait_ready("fill", low);
        end
        check_val("fill_col", {30'd0, cursor_col}, 32'd3);
        clear_q();
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h62);
        wait_ready("wrap0", low);
        check_val("wrap0_nstrobes", sd_q.size(), 32'd2);
        check_strobe("wrap0_b", 0, 8'h62, 1'b1);
        check_strobe("wrap0_addr", 1, 8'h80, 1'b0);
        check_val("wrap0_col", {30'd0, cursor_col}, 32'd0);
        check_val("wrap0_row", {31'd0, cursor_row}, 32'd0);

        // done beats letter: newline to row 1, no data byte.
        clear_q();
        send_req(1'b1, 1'b0, 1'b1, 1'b0, 8'h71);
        wait_ready("nl", low);
        check_val("nl_nstrobes", sd_q.size(), 32'd1);
        check_strobe("nl", 0, 8'hC0, 1'b0);
        check_val("nl_col", {30'd0, cursor_col}, 32'd0);
        check_val("nl_row", {31'd0, cursor_row}, 32'd1);

        // Word space.
        clear_q();
        send_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        wait_ready("sp", low);
        check_val("sp_nstrobes", sd_q.size(), 32'd1);
        check_strobe("sp", 0, 8'h20, 1'b1);
        check_val("sp_col", {30'd0, cursor_col}, 32'd1);

        // Non-printable code passes through; a request while busy is dropped.
        clear_q();
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h58);
        wait_ready("drop", low);
        check_val("drop_nstrobes", sd_q.size(), 32'd1);
        check_strobe("drop", 0, 8'h07, 1'b1);
        check_val("drop_col", {30'd0, cursor_col}, 32'd2);

        // Reset while E is high aborts the strobe and reruns init.
        send_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h31);
        low = 0;
        while (!lcd_e && low < 50) begin
            low++;
            @(negedge sysclk);
        end
        check_val("mid_e_high", {31'd0, lcd_e}, 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check_val("mid_e_drop", {31'd0, lcd_e}, 32'd0);
        check_val("mid_ready", {31'd0, ready}, 32'd0);
        check_val("mid_col", {30'd0, cursor_col}, 32'd0);
        repeat (2) @(negedge sysclk);
        rel_cyc = cyc;
        clr_n = 1'b1;
        clear_q();
        check_init("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
